// File: rtl/sr_latch_sequencer_pkg.sv
// Shared types for the SR latch sequencer slice.
//   state_t  : sequencer FSM states
//   OP_SET   : opcode driving the latch S input
//   OP_RESET : opcode driving the latch R input
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/sr_latch_sequencer_if.sv
// Request bundle between NREQ requesters and the SR latch sequencer.
//   req_valid : per-requester request, held until acknowledged
//   req_op    : per-requester opcode (1=SET, 0=RESET), stable while valid
//   req_ack   : one-hot, single-cycle acknowledge of the granted request
// master = requester side, slave = sequencer side.
interface sr_latch_sequencer_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_op;
  logic [NREQ-1:0] req_ack;

  modport master (
    output req_valid,
    output req_op,
    input  req_ack
  );

  modport slave (
    input  req_valid,
    input  req_op,
    output req_ack
  );

endinterface

// File: rtl/sr_latch_sequencer_rr.sv
// Round-robin arbiter used by the SR latch sequencer.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req        : request vector
//   advance    : accept the current grant; pointer moves to grantee+1 (mod NREQ)
//   grant      : combinational one-hot grant, search starts at the pointer
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] sel;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant = '0;
    gidx  = ptr;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        gidx       = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (32'(gidx) == NREQ - 1) ? '0 : gidx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Serialises SET/RESET requests from NREQ requesters onto one NOR SR latch.
//   clk, rst_n   : clock, synchronous active-low reset
//   req          : request bundle (valid/op in, one-hot ack out)
//   latch_s/r    : latch drive, never both high; reset forces latch_r=1
//   latch_q      : latch Q feedback, sampled in CHECK
//   q_expected   : latch state after the last completed op
//   busy         : high while an operation is in PULSE/GAP/CHECK
//   err_mismatch : sticky Q-vs-expected mismatch flag, cleared only by reset
// All outputs are registered.
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_latch_sequencer_if.slave req,
  output logic                latch_s,
  output logic                latch_r,
  input  logic                latch_q,
  output logic                q_expected,
  output logic                busy,
  output logic                err_mismatch
);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [NREQ-1:0]  ack_q;
  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  grant;
  logic             op_q;
  logic             go_q;
  logic             grant_ok;
  logic             any_grant;
  logic             gnt_op;
  logic             redundant;

  // The ack is registered, so the acked requester still shows valid at the
  // following edge; mask it to avoid a double grant.
  assign arb_req = req.req_valid & ~ack_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (any_grant),
    .grant   (grant)
  );

  // Grant is decided at the edge that opens the ack cycle; the ack cycle
  // itself is spent in IDLE (go_q pending) so the pulse starts one cycle after
  // the ack. Grants are only taken when the next cycle is an IDLE cycle.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (go_q) begin
          nxt     = PULSE;
          cnt_nxt = CNT_W'(PULSE_W);
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(1)) begin
          nxt     = GAP;
          cnt_nxt = CNT_W'(GAP_W);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(1)) begin
          nxt     = CHECK;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      CHECK: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    grant_ok  = (nxt == IDLE);
    any_grant = grant_ok && (|grant);
    gnt_op    = |(grant & req.req_op);
    redundant = (gnt_op == q_expected);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ack_q        <= '0;
      op_q         <= OP_RESET;
      go_q         <= 1'b0;
      latch_s      <= 1'b0;
      latch_r      <= 1'b1;
      q_expected   <= 1'b0;
      busy         <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      ack_q   <= any_grant ? grant : '0;
      go_q    <= any_grant && !redundant;
      if (any_grant) begin
        op_q <= gnt_op;
      end
      latch_s <= (nxt == PULSE) && (op_q == OP_SET);
      latch_r <= (nxt == PULSE) && (op_q == OP_RESET);
      busy    <= (nxt != IDLE);
      if (state == PULSE && nxt == GAP) begin
        q_expected <= op_q;
      end
      if (state == CHECK && latch_q != q_expected) begin
        err_mismatch <= 1'b1;
      end
    end
  end

  assign req.req_ack = ack_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed self-checking bench for sr_latch_sequencer (NREQ=4, PULSE_W=2, GAP_W=1).
module tb_sr_latch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic latch_s, latch_r, latch_q, q_expected, busy, err_mismatch;
  logic force_q0 = 1'b0;
  logic model_q = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned viol_sr = 0;
  int unsigned viol_ack = 0;

  sr_latch_sequencer_if #(.NREQ(4)) rif ();

  sr_latch_sequencer #(
    .NREQ    (4),
    .PULSE_W (2),
    .GAP_W   (1),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (rif.slave),
    .latch_s      (latch_s),
    .latch_r      (latch_r),
    .latch_q      (latch_q),
    .q_expected   (q_expected),
    .busy         (busy),
    .err_mismatch (err_mismatch)
  );

  always #5 clk = ~clk;

  // Clocked NOR latch stand-in; force_q0 emulates a latch stuck at 0.
  always @(posedge clk) begin
    if (force_q0)     model_q <= 1'b0;
    else if (latch_s) model_q <= 1'b1;
    else if (latch_r) model_q <= 1'b0;
  end
  assign latch_q = model_q;

  always @(negedge clk) begin
    assert (!(latch_s && latch_r));
    if (latch_s && latch_r) viol_sr++;
    if ($countones(rif.req_ack) > 1) viol_ack++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request, wait (bounded) for its ack, then withdraw it.
  task automatic do_op(input int unsigned idx, input logic op, input string tag);
    logic [3:0] bitm;
    int unsigned n;
    bitm = 4'(1) << idx;
    rif.req_op    = op ? (rif.req_op | bitm) : (rif.req_op & ~bitm);
    rif.req_valid = rif.req_valid | bitm;
    n = 0;
    do begin
      tick();
      n++;
    end while (rif.req_ack == 4'b0 && n < 30);
    check({tag, "_ack"}, 32'(rif.req_ack), 32'(bitm));
    rif.req_valid = rif.req_valid & ~bitm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int unsigned order [4];
  int unsigned when  [4];
  int unsigned nack;
  int unsigned cyc;
  logic [3:0]  seen;

  initial begin
    rif.req_valid = '0;
    rif.req_op    = '0;

    // 1. reset state
    repeat (3) tick();
    check("rst_latch_r", 32'(latch_r), 32'd1);
    check("rst_latch_s", 32'(latch_s), 32'd0);
    check("rst_q_exp",   32'(q_expected), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_ack",     32'(rif.req_ack), 32'd0);
    check("rst_err",     32'(err_mismatch), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_latch_r", 32'(latch_r), 32'd0);

    // 2. single SET from requester 0: ack at T, S at T+1..T+2, CHECK at T+4
    do_op(0, 1'b1, "set0");
    tick();
    check("set0_s_t1", 32'({latch_s, latch_r, busy}), 32'b101);
    tick();
    check("set0_s_t2", 32'({latch_s, latch_r, busy}), 32'b101);
    tick();
    check("set0_gap",  32'({latch_s, latch_r, busy, q_expected}), 32'b0011);
    tick();
    check("set0_chk",  32'(busy), 32'd1);
    tick();
    check("set0_done", 32'({busy, q_expected, err_mismatch}), 32'b010);

    // 3. all four valid from pointer 0: acks 0,1,2,3 with gaps 5,1,5
    do_reset();
    rif.req_op    = 4'b0011;
    rif.req_valid = 4'b1111;
    nack = 0;
    cyc  = 0;
    while (nack < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (rif.req_ack != 4'b0) begin
        order[nack] = $clog2(32'(rif.req_ack));
        when[nack]  = cyc;
        nack++;
        rif.req_valid = rif.req_valid & ~rif.req_ack;
      end
    end
    check("rr_count", nack, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], 32'(i));
    check("rr_gap01", when[1] - when[0], 32'd5);
    check("rr_gap12", when[2] - when[1], 32'd1);
    check("rr_gap23", when[3] - when[2], 32'd1 + 32'd4);
    repeat (6) tick();
    check("rr_q_exp", 32'({q_expected, err_mismatch, busy}), 32'b000);

    // next round restarts at 0; the others withdraw before being acked
    rif.req_op    = 4'b0001;
    rif.req_valid = 4'b1111;
    tick();
    check("rr2_first", 32'(rif.req_ack), 32'b0001);
    rif.req_valid = '0;
    repeat (6) tick();
    seen = '0;
    repeat (4) begin
      tick();
      seen = seen | rif.req_ack;
    end
    check("rr2_withdrawn", 32'(seen), 32'd0);
    check("rr2_q_exp", 32'(q_expected), 32'd1);

    // 4. redundant SET: ack only, no pulse
    do_op(2, 1'b1, "redund");
    check("redund_busy_ack", 32'(busy), 32'd0);
    tick();
    check("redund_no_pulse", 32'({latch_s, latch_r, busy, q_expected}), 32'b0001);

    // 5. stuck latch: mismatch flagged at CHECK and sticky
    do_op(3, 1'b0, "clr");
    repeat (6) tick();
    check("clr_state", 32'({q_expected, err_mismatch}), 32'b00);
    force_q0 = 1'b1;
    do_op(0, 1'b1, "stuck");
    repeat (4) tick();
    check("stuck_pre", 32'({busy, err_mismatch}), 32'b10);
    tick();
    check("stuck_err", 32'({busy, err_mismatch, q_expected}), 32'b011);
    force_q0 = 1'b0;
    do_op(1, 1'b0, "after");
    repeat (6) tick();
    check("err_sticky", 32'({err_mismatch, q_expected}), 32'b10);
    do_reset();
    check("err_cleared", 32'(err_mismatch), 32'd0);

    // 6. reset in the middle of a SET pulse aborts it
    do_op(2, 1'b1, "abort");
    tick();
    check("abort_pulse", 32'(latch_s), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_rst", 32'({latch_s, latch_r, busy, q_expected}), 32'b0100);
    rst_n = 1'b1;
    seen = '0;
    repeat (8) begin
      tick();
      seen = seen | rif.req_ack;
    end
    check("abort_no_reack", 32'(seen), 32'd0);
    check("abort_idle", 32'({busy, latch_s, latch_r}), 32'b000);

    check("sr_never_both", viol_sr, 32'd0);
    check("ack_onehot", viol_ack, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
